// File: rtl/convolution_processor_accumulator_if.sv
// Stream-side signals of the convolution accumulator: run control, product input
// handshake and result output handshake.
interface convolution_processor_accumulator_if #(
   parameter int PRODUCT_WIDTH = 16,
   parameter int DATA_WIDTH    = 22,
   parameter int LEN_WIDTH     = 8
);
   logic                     start;
   logic [LEN_WIDTH-1:0]     length;
   logic                     abort;
   logic [PRODUCT_WIDTH-1:0] in_data;
   logic                     in_valid;
   logic                     in_ready;
   logic [DATA_WIDTH-1:0]    out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic                     busy;

   modport slave (
      input  start, length, abort, in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, busy
   );

   modport master (
      output start, length, abort, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, busy
   );
endinterface

// File: rtl/convolution_processor_accumulator.sv
// Sums a programmed number of signed products into one convolution output sample,
// then presents the sum on a valid/ready output until it is taken.
module convolution_processor_accumulator #(
   parameter int PRODUCT_WIDTH = 16,
   parameter int DATA_WIDTH    = 22,
   parameter int LEN_WIDTH     = 8
) (
   input  logic clk,
   input  logic rst,
   convolution_processor_accumulator_if.slave ifc
);
   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

   state_t                state_q,     state_d;
   logic [DATA_WIDTH-1:0] acc_q,       acc_d;
   logic [LEN_WIDTH-1:0]  count_q,     count_d;
   logic [LEN_WIDTH-1:0]  len_q,       len_d;
   logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
   logic                  in_ready_q,  in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic                  busy_q,      busy_d;

   logic                  xfer;
   logic [DATA_WIDTH-1:0] term_ext;
   logic [DATA_WIDTH-1:0] sum;

   assign xfer     = ifc.in_valid & in_ready_q;
   assign term_ext = DATA_WIDTH'($signed(ifc.in_data));
   assign sum      = acc_q + term_ext;

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      count_d    = count_q;
      len_d      = len_q;
      out_data_d = out_data_q;
      case (state_q)
         IDLE: begin
            if (ifc.start) begin
               len_d   = ifc.length;
               acc_d   = '0;
               count_d = '0;
               if (ifc.length != '0) begin
                  state_d = ACC;
               end else begin
                  out_data_d = '0;
                  state_d    = OUT;
               end
            end
         end
         ACC: begin
            if (xfer) begin
               acc_d   = sum;
               count_d = count_q + LEN_WIDTH'(1);
               if (count_q == len_q - LEN_WIDTH'(1)) begin
                  out_data_d = sum;
                  state_d    = OUT;
               end
            end
         end
         OUT: begin
            if (ifc.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Abort overrides any start or transfer decided above; out_data is kept.
      if (ifc.abort) begin
         state_d = IDLE;
         acc_d   = '0;
         count_d = '0;
      end
      in_ready_d  = (state_d == ACC);
      out_valid_d = (state_d == OUT);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         count_q     <= '0;
         len_q       <= '0;
         out_data_q  <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         len_q       <= len_d;
         out_data_q  <= out_data_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign ifc.in_ready  = in_ready_q;
   assign ifc.out_data  = out_data_q;
   assign ifc.out_valid = out_valid_q;
   assign ifc.busy      = busy_q;
endmodule

// File: tb/tb_convolution_processor_accumulator.sv
// Directed bench for the convolution accumulator: hand-computed sums, stalls,
// zero-length runs, wrap-around, reset and abort mid-run.
module tb_convolution_processor_accumulator;
   localparam int PW = 16;
   localparam int DW = 22;
   localparam int LW = 8;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   convolution_processor_accumulator_if #(.PRODUCT_WIDTH(PW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) ifc ();

   convolution_processor_accumulator #(.PRODUCT_WIDTH(PW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk (clk),
      .rst (rst),
      .ifc (ifc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag, input logic [DW-1:0] exp_data);
      check({tag, ".in_ready"},  32'(ifc.in_ready),  32'd0);
      check({tag, ".out_valid"}, 32'(ifc.out_valid), 32'd0);
      check({tag, ".busy"},      32'(ifc.busy),      32'd0);
      check({tag, ".out_data"},  32'(ifc.out_data),  32'(exp_data));
   endtask

   task automatic check_out(input string tag, input logic [DW-1:0] exp_data);
      check({tag, ".out_valid"}, 32'(ifc.out_valid), 32'd1);
      check({tag, ".in_ready"},  32'(ifc.in_ready),  32'd0);
      check({tag, ".busy"},      32'(ifc.busy),      32'd1);
      check({tag, ".out_data"},  32'(ifc.out_data),  32'(exp_data));
   endtask

   task automatic start_run(input logic [LW-1:0] len);
      ifc.start  = 1'b1;
      ifc.length = len;
      tick();
      ifc.start  = 1'b0;
   endtask

   task automatic push(input logic [PW-1:0] d);
      ifc.in_valid = 1'b1;
      ifc.in_data  = d;
      tick();
      ifc.in_valid = 1'b0;
   endtask

   task automatic drain();
      ifc.out_ready = 1'b1;
      tick();
      ifc.out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ifc.start = 1'b0; ifc.length = '0; ifc.abort = 1'b0;
      ifc.in_data = '0; ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
      tick(); tick();
      check_idle("reset", '0);
      rst = 1'b0;

      // 1: four back-to-back terms
      start_run(8'd4);
      check("t1.busy", 32'(ifc.busy), 32'd1);
      check("t1.in_ready", 32'(ifc.in_ready), 32'd1);
      for (int i = 1; i <= 3; i++) push(16'(i));
      check("t1.no_early_valid", 32'(ifc.out_valid), 32'd0);
      push(16'd4);
      check_out("t1", 22'd10);
      drain();
      check_idle("t1.done", 22'd10);

      // 2: signed terms, started right after returning to IDLE
      start_run(8'd2);
      push(16'hFFFB);
      push(16'd3);
      check_out("t2", 22'h3FFFFE);
      drain();

      // 3: input gaps, late length change, long output stall
      start_run(8'd3);
      ifc.length = 8'd1;
      for (int k = 1; k <= 3; k++) begin
         ifc.in_data = 16'h0777;
         tick(); tick();
         check("t3.gap_hold", 32'(ifc.out_valid), 32'd0);
         push(16'(k * 10));
      end
      ifc.in_valid = 1'b1; ifc.in_data = 16'd100; ifc.start = 1'b1;
      for (int c = 0; c < 5; c++) begin
         check_out("t3.stall", 22'd60);
         tick();
      end
      ifc.start = 1'b0;
      drain();
      tick();
      check_idle("t3.extra_ignored", 22'd60);
      ifc.in_valid = 1'b0;

      // 4: zero-length run
      start_run(8'd0);
      check_out("t4", 22'd0);
      drain();

      // 5: reach 2^21-1 then add +1 to wrap
      start_run(8'd66);
      for (int i = 0; i < 64; i++) push(16'h7FFF);
      push(16'd63);
      check("t5.pre_wrap", 32'(ifc.out_valid), 32'd0);
      push(16'd1);
      check_out("t5", 22'h200000);
      drain();

      // 6a: reset mid-run clears everything including out_data
      start_run(8'd5);
      push(16'd11); push(16'd12);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("t6.rst", 22'd0);
      start_run(8'd1);
      push(16'd7);
      check_out("t6.rst_run", 22'd7);
      drain();

      // 6b: abort mid-run with a concurrent transfer; out_data retained
      start_run(8'd5);
      push(16'd11); push(16'd12);
      ifc.abort = 1'b1; ifc.in_valid = 1'b1; ifc.in_data = 16'd13;
      tick();
      ifc.abort = 1'b0; ifc.in_valid = 1'b0;
      check_idle("t6.abort", 22'd7);
      tick();
      check("t6.abort_no_valid", 32'(ifc.out_valid), 32'd0);
      start_run(8'd1);
      push(16'd7);
      check_out("t6.abort_run", 22'd7);
      drain();

      // abort beats start in IDLE
      ifc.abort = 1'b1; ifc.start = 1'b1; ifc.length = 8'd3;
      tick();
      ifc.abort = 1'b0; ifc.start = 1'b0;
      check("abort_vs_start.busy", 32'(ifc.busy), 32'd0);

      // abort during OUT drops out_valid without a handshake
      start_run(8'd1);
      push(16'h8000);
      check_out("abort_out.pre", 22'h3F8000);
      ifc.abort = 1'b1;
      tick();
      ifc.abort = 1'b0;
      check_idle("abort_out", 22'h3F8000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
